// File: rtl/fetch_regs.sv
// Y86-64 F and D pipeline registers: fetch PC selection (mispredict / ret
// redirect), next-PC prediction, and capture of fetched fields into D.
module fetch_regs #(
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  M_icode,
  input  logic        M_cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic [2:0]  f_stat,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  output logic [63:0] f_pc,
  output logic [63:0] F_predPC,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP
);

  localparam logic [3:0] ICODE_NOP  = 4'h1;
  localparam logic [3:0] ICODE_JXX  = 4'h7;
  localparam logic [3:0] ICODE_CALL = 4'h8;
  localparam logic [3:0] ICODE_RET  = 4'h9;
  localparam logic [3:0] REG_NONE   = 4'hF;
  localparam logic [2:0] STAT_AOK   = 3'd1;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } d_reg_t;

  localparam d_reg_t D_BUBBLE = '{
    stat:  STAT_AOK,
    icode: ICODE_NOP,
    ifun:  4'h0,
    ra:    REG_NONE,
    rb:    REG_NONE,
    valc:  64'd0,
    valp:  64'd0
  };

  logic [63:0] f_pred_pc;
  logic [63:0] pred_pc_d, pred_pc_q;
  d_reg_t      d_reg_d, d_reg_q;

  // Mispredict recovery outranks ret completion; both outrank the prediction.
  always_comb begin
    f_pc = pred_pc_q;
    if (M_icode == ICODE_JXX && !M_cnd) begin
      f_pc = M_valA;
    end else if (W_icode == ICODE_RET) begin
      f_pc = W_valM;
    end
  end

  always_comb begin
    f_pred_pc = f_valP;
    if (f_icode == ICODE_JXX || f_icode == ICODE_CALL) begin
      f_pred_pc = f_valC;
    end
  end

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pred_pc_d = F_stall ? pred_pc_q : f_pred_pc;

    d_reg_d = '{
      stat:  f_stat,
      icode: f_icode,
      ifun:  f_ifun,
      ra:    f_rA,
      rb:    f_rB,
      valc:  f_valC,
      valp:  f_valP
    };
    // Stall beats bubble so an illegal stall+bubble still yields a defined value.
    if (D_stall) begin
      d_reg_d = d_reg_q;
    end else if (D_bubble) begin
      d_reg_d = D_BUBBLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_pc_q <= RESET_PC;
      d_reg_q   <= D_BUBBLE;
    end else begin
      pred_pc_q <= pred_pc_d;
      d_reg_q   <= d_reg_d;
    end
  end

  assign F_predPC = pred_pc_q;
  assign D_stat   = d_reg_q.stat;
  assign D_icode  = d_reg_q.icode;
  assign D_ifun   = d_reg_q.ifun;
  assign D_rA     = d_reg_q.ra;
  assign D_rB     = d_reg_q.rb;
  assign D_valC   = d_reg_q.valc;
  assign D_valP   = d_reg_q.valp;

endmodule

// File: tb/tb_fetch_regs.sv
// Self-checking bench for fetch_regs: directed literal checks followed by
// randomized stimulus compared every cycle against a behavioural model.
module tb_fetch_regs;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        F_stall, D_stall, D_bubble;
  logic [3:0]  M_icode;
  logic        M_cnd;
  logic [63:0] M_valA;
  logic [3:0]  W_icode;
  logic [63:0] W_valM;
  logic [2:0]  f_stat;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic [63:0] f_pc, F_predPC;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;

  fetch_regs #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .M_icode(M_icode), .M_cnd(M_cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun),
    .f_rA(f_rA), .f_rB(f_rB), .f_valC(f_valC), .f_valP(f_valP),
    .f_pc(f_pc), .F_predPC(F_predPC),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
    .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: the D register is an instruction record; F holds a PC.
  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
  } instr_t;

  instr_t      m_d;
  logic [63:0] m_pred;
  bit          model_valid = 0;

  function automatic instr_t nop_instr();
    instr_t n;
    n.stat = 3'd1; n.icode = 4'h1; n.ifun = 4'h0;
    n.ra = 4'hF; n.rb = 4'hF; n.valc = 64'd0; n.valp = 64'd0;
    return n;
  endfunction

  function automatic logic [63:0] expected_fpc();
    if (M_icode == 4'd7 && M_cnd == 1'b0) return M_valA;
    if (W_icode == 4'd9) return W_valM;
    return m_pred;
  endfunction

  always @(posedge clk) begin
    instr_t fetched;
    fetched.stat = f_stat; fetched.icode = f_icode; fetched.ifun = f_ifun;
    fetched.ra = f_rA; fetched.rb = f_rB; fetched.valc = f_valC; fetched.valp = f_valP;
    if (!rst_n) begin
      m_pred = RST_PC;
      m_d = nop_instr();
      model_valid = 1;
    end else begin
      if (!F_stall) m_pred = (f_icode == 4'd7 || f_icode == 4'd8) ? f_valC : f_valP;
      if (!D_stall) m_d = D_bubble ? nop_instr() : fetched;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("f_pc", f_pc, expected_fpc());
      check("F_predPC", F_predPC, m_pred);
      check("D_stat", {61'd0, D_stat}, {61'd0, m_d.stat});
      check("D_icode", {60'd0, D_icode}, {60'd0, m_d.icode});
      check("D_ifun", {60'd0, D_ifun}, {60'd0, m_d.ifun});
      check("D_rA", {60'd0, D_rA}, {60'd0, m_d.ra});
      check("D_rB", {60'd0, D_rB}, {60'd0, m_d.rb});
      check("D_valC", D_valC, m_d.valc);
      check("D_valP", D_valP, m_d.valp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input logic [3:0] icode, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [63:0] valc,
                           input logic [63:0] valp);
    f_stat = 3'd1; f_icode = icode; f_ifun = 4'h0;
    f_rA = ra; f_rB = rb; f_valC = valc; f_valP = valp;
  endtask

  initial begin
    rst_n = 1'b0; F_stall = 0; D_stall = 0; D_bubble = 0;
    M_icode = 4'd0; M_cnd = 0; M_valA = 64'd0;
    W_icode = 4'd0; W_valM = 64'd0;
    set_fetch(4'h0, 4'hF, 4'hF, 64'd0, 64'd0);

    // Reset for two cycles
    tick(); tick();
    check("rst F_predPC", F_predPC, 64'h100);
    check("rst f_pc", f_pc, 64'h100);
    check("rst D_icode", {60'd0, D_icode}, 64'd1);
    check("rst D_stat", {61'd0, D_stat}, 64'd1);
    check("rst D_rA", {60'd0, D_rA}, 64'hF);
    check("rst D_rB", {60'd0, D_rB}, 64'hF);
    check("rst D_valC", D_valC, 64'd0);
    check("rst D_valP", D_valP, 64'd0);

    // Sequential irmovq then call
    rst_n = 1'b1;
    set_fetch(4'h3, 4'hF, 4'h2, 64'h5, 64'h10);
    tick();
    check("seq F_predPC", F_predPC, 64'h10);
    check("seq D_icode", {60'd0, D_icode}, 64'd3);
    check("seq D_valP", D_valP, 64'h10);
    set_fetch(4'h8, 4'hF, 4'h4, 64'h40, 64'h19);
    tick();
    check("call F_predPC", F_predPC, 64'h40);
    check("call D_icode", {60'd0, D_icode}, 64'd8);
    check("call D_valC", D_valC, 64'h40);
    check("call D_valP", D_valP, 64'h19);

    // F and D stall for two cycles
    F_stall = 1; D_stall = 1;
    set_fetch(4'h6, 4'h1, 4'h2, 64'h77, 64'h80);
    tick(); tick();
    check("stall F_predPC", F_predPC, 64'h40);
    check("stall D_icode", {60'd0, D_icode}, 64'd8);
    check("stall D_valC", D_valC, 64'h40);

    // Stall beats bubble
    F_stall = 0; D_bubble = 1;
    tick();
    check("stall+bubble D_icode", {60'd0, D_icode}, 64'd8);
    check("stall+bubble D_valP", D_valP, 64'h19);
    check("opq F_predPC", F_predPC, 64'h80);

    // Bubble alone
    F_stall = 1; D_stall = 0;
    tick();
    check("bubble D_icode", {60'd0, D_icode}, 64'd1);
    check("bubble D_rA", {60'd0, D_rA}, 64'hF);
    check("bubble D_valP", D_valP, 64'd0);

    // Mispredict and ret redirects (F_predPC == 0x80)
    M_icode = 4'd7; M_cnd = 0; M_valA = 64'h2A;
    #1 check("mispredict f_pc", f_pc, 64'h2A);
    M_cnd = 1;
    #1 check("taken f_pc", f_pc, 64'h80);
    W_icode = 4'd9; W_valM = 64'h1234;
    #1 check("ret f_pc", f_pc, 64'h1234);
    M_cnd = 0;
    #1 check("mispredict over ret f_pc", f_pc, 64'h2A);

    // Reset during stall
    M_icode = 4'd0; W_icode = 4'd0;
    F_stall = 1; D_stall = 1; D_bubble = 0; rst_n = 0;
    tick();
    check("rst-stall F_predPC", F_predPC, 64'h100);
    check("rst-stall D_icode", {60'd0, D_icode}, 64'd1);
    check("rst-stall D_rB", {60'd0, D_rB}, 64'hF);
    rst_n = 1; F_stall = 0; D_stall = 0;

    // Randomized phase, checked by the per-cycle compare process
    for (int i = 0; i < 2000; i++) begin
      rst_n    = ($urandom_range(0, 49) != 0);
      F_stall  = ($urandom_range(0, 3) == 0);
      D_stall  = ($urandom_range(0, 3) == 0);
      D_bubble = ($urandom_range(0, 3) == 0);
      M_icode  = ($urandom_range(0, 2) == 0) ? 4'd7 : 4'($urandom);
      M_cnd    = 1'($urandom);
      M_valA   = {$urandom, $urandom};
      W_icode  = ($urandom_range(0, 3) == 0) ? 4'd9 : 4'($urandom);
      W_valM   = {$urandom, $urandom};
      f_stat   = 3'($urandom_range(1, 4));
      f_icode  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(7, 8)) : 4'($urandom);
      f_ifun   = 4'($urandom);
      f_rA     = 4'($urandom);
      f_rB     = 4'($urandom);
      f_valC   = {$urandom, $urandom};
      f_valP   = {$urandom, $urandom};
      tick();
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_regs.md
# fetch_regs

Owns the F and D pipeline registers of the Y86-64 five-stage pipeline. It selects the fetch PC, covering branch misprediction recovery and `ret` return. It computes and latches the predicted next PC, and captures fetched instruction fields into the D register. It consumes `F_stall`, `D_stall` and `D_bubble` from the pipeline hazard control unit and feeds the decode stage.

## Interface
Parameters:
- `RESET_PC`, 64'd0, value loaded into `F_predPC` on reset.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `F_stall`  in  1  hold the F register.
- `D_stall`  in  1  hold the D register.
- `D_bubble`  in  1  load a nop into the D register.
- `M_icode`  in  4  icode in the M register.
- `M_cnd`  in  1  condition latched with the M-stage instruction.
- `M_valA`  in  64  fall-through PC of the M-stage jump.
- `W_icode`  in  4  icode in the W register.
- `W_valM`  in  64  return address read by the W-stage `ret`.
- `f_stat`  in  3  fetch status: AOK=1, HLT=2, ADR=3, INS=4.
- `f_icode`, `f_ifun`  in  4 each  fetched opcode and function.
- `f_rA`, `f_rB`  in  4 each  fetched register IDs; 4'hF means none.
- `f_valC`  in  64  fetched constant.
- `f_valP`  in  64  address of the next sequential instruction.
- `f_pc`  out  64  combinational fetch address to instruction memory.
- `F_predPC`  out  64  registered predicted PC.
- `D_stat`  out  3  registered status.
- `D_icode`, `D_ifun`, `D_rA`, `D_rB`  out  4 each  registered fields.
- `D_valC`, `D_valP`  out  64 each  registered constant and sequential PC.

## Operation
- PC select is combinational, first match wins:
  1. `M_icode==7 && !M_cnd`: `f_pc=M_valA`. This is a mispredicted jump.
  2. `W_icode==9`: `f_pc=W_valM`. This is `ret` completion.
  3. Otherwise: `f_pc=F_predPC`.
- Predicted next PC, `f_predPC`, is internal and combinational:
  - `f_valC` when `f_icode` is 7 (jXX) or 8 (call).
  - `f_valP` for all other icodes, including invalid ones.
- F register update:
  - `!rst_n`: `RESET_PC`.
  - else `F_stall`: hold.
  - else: `f_predPC`.
- D register update:
  - `!rst_n`: bubble values.
  - else `D_stall`: hold all fields.
  - else `D_bubble`: bubble values.
  - else: load `f_*` fields.
- Bubble values: stat=1, icode=1 (nop), ifun=0, rA=rB=4'hF, valC=0, valP=0.
- If `D_stall` and `D_bubble` are both asserted, the stall wins. Control never drives both; the block must not produce X in that case.
- Stall and bubble inputs are not checked for legality beyond the precedence above.
- `f_stat` is passed through unchanged. HLT, ADR and INS do not alter PC selection or the update of either register; exception freezing is done downstream by M_bubble and W_stall.
- Address arithmetic is full 64-bit. No increment happens inside this block; `f_valP` is supplied by the aligner. There is no overflow handling; values wrap naturally.

## Timing
- `f_pc` is valid in the same cycle as `M_*`/`W_*` and `F_predPC`. It is a zero-latency combinational path.
- Fetched fields appear on the `D_*` outputs one cycle after capture.
- `F_predPC` updates one cycle after `f_predPC` is computed.
- Reset values after the first rising edge with `rst_n=0`:
  - `F_predPC = RESET_PC`.
  - `D_*` = bubble values.
  - `f_pc` = `RESET_PC` unless a redirect condition is present on the inputs.
- Reset asserted mid-stall or mid-bubble: reset overrides on that edge.
- Deasserting `rst_n` takes effect at the next edge. No extra wait cycles.
- Mispredict cycle:
  - `f_pc=M_valA` that cycle.
  - Control asserts `D_bubble`, so the wrongly fetched instruction in D becomes a nop.
  - F loads the prediction for the corrected instruction.
- `ret` sequence:
  - While `ret` is in D, E and M, control holds F (`F_stall`) and bubbles D.
  - In the cycle `W_icode==9`, `f_pc=W_valM`.
- Simultaneous mispredict and `ret`-in-W: mispredict wins. This cannot occur in legal sequences but the priority is fixed.

## Test plan
- Reset:
  - Stimulus: hold `rst_n=0` for 2 cycles with `RESET_PC=64'h100`, then release.
  - Required: `F_predPC=0x100`, `f_pc=0x100`; D shows icode=1, stat=1, rA=rB=F, valC=valP=0.
- Sequential plus call:
  - Stimulus: fetch `irmovq` with `f_valP=0x10`, then `call` with `f_valC=0x40`, `f_valP=0x19`.
  - Required: `F_predPC` becomes 0x10, then 0x40. D captures each instruction one cycle later.
- Stall/bubble precedence:
  - Stimulus 1: `F_stall=D_stall=1` for 2 cycles.
  - Required: `F_predPC` and all `D_*` unchanged.
  - Stimulus 2: `D_stall=D_bubble=1`.
  - Required: D holds its contents.
  - Stimulus 3: `D_bubble=1` alone.
  - Required: D becomes the nop bubble.
- Mispredict:
  - Stimulus: `M_icode=7`, `M_cnd=0`, `M_valA=0x2A`, `F_predPC=0x80`.
  - Required: `f_pc=0x2A`.
  - Stimulus: same with `M_cnd=1`.
  - Required: `f_pc=0x80`.
- Ret:
  - Stimulus: `W_icode=9`, `W_valM=0x1234`.
  - Required: `f_pc=0x1234`.
  - Stimulus: the same cycle with a mispredict also present.
  - Required: `f_pc=M_valA`.
- Reset mid-stall:
  - Stimulus: assert `F_stall=1`, `D_stall=1` with `rst_n=0`.
  - Required: next edge gives `F_predPC=RESET_PC` and D = bubble values.
